// File: rtl/capacitive_touch_scanner.sv
// Capacitive touch scanner for nine pads sharing one drive pin.
// Each scan discharges the pads, then times how long every pad takes to read
// high after the drive pin goes high; slow pads are reported as touched.
// Optional feature macro: CAP_DEBOUNCE_EN adds per-pad scan-to-scan debounce.
module capacitive_touch_scanner #(
  parameter int unsigned DISCHARGE_CYCLES = 256,
  parameter int unsigned TIMEOUT_CYCLES   = 4095,
  parameter int unsigned THRESHOLD        = 200,
  parameter int unsigned DEBOUNCE_SCANS   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] capacitive_sensors_in,
  output logic       capacitive_sensors_out,
  output logic [8:0] touched,
  output logic [8:0] touch_rise,
  output logic       scan_done,
  output logic       busy
);

  localparam int unsigned NUM_PADS = 9;
  localparam int unsigned CNT_W    = 12;
  localparam int unsigned DIS_W    = $clog2(DISCHARGE_CYCLES + 1);

  // Reject debounce depths the 2-bit agreement counter cannot represent.
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 4) begin : g_cfg_check
    $error("DEBOUNCE_SCANS must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    CHARGE    = 2'd2,
    EVAL      = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [NUM_PADS-1:0]  meta_q;
  logic [NUM_PADS-1:0]  sync_q;
  logic [DIS_W-1:0]     dis_cnt_q;
  logic [CNT_W-1:0]     chg_cnt_q;
  logic [NUM_PADS-1:0]  captured_q;
  logic [CNT_W-1:0]     rise_q [NUM_PADS];
  logic                 timeout_c;
  logic                 out_c;
  logic                 busy_c;
  logic [NUM_PADS-1:0]  raw_c;
  logic [NUM_PADS-1:0]  touched_c;

  assign timeout_c = (chg_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Two-flop synchronizer for the asynchronous pad inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= capacitive_sensors_in;
      sync_q <= meta_q;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a started scan always runs through EVAL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = DISCHARGE;
      end
      DISCHARGE: begin
        if (dis_cnt_q == DIS_W'(DISCHARGE_CYCLES - 1)) state_d = CHARGE;
      end
      CHARGE: begin
        if ((&captured_q) || timeout_c) state_d = EVAL;
      end
      EVAL: begin
        state_d = enable ? DISCHARGE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase counters: zero on the first cycle of their phase, cleared outside it.
  always_ff @(posedge clock) begin
    if (reset) begin
      dis_cnt_q <= '0;
      chg_cnt_q <= '0;
    end else begin
      dis_cnt_q <= (state_q == DISCHARGE && state_d == DISCHARGE) ? dis_cnt_q + DIS_W'(1) : '0;
      chg_cnt_q <= (state_q == CHARGE && state_d == CHARGE) ? chg_cnt_q + CNT_W'(1) : '0;
    end
  end

  // Rise-time capture: first high sample wins; timeout fills in the stragglers.
  always_ff @(posedge clock) begin
    if (reset) begin
      captured_q <= '0;
      for (int i = 0; i < NUM_PADS; i++) rise_q[i] <= '0;
    end else if (state_q == DISCHARGE) begin
      captured_q <= '0;
    end else if (state_q == CHARGE) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        if (!captured_q[i] && (sync_q[i] || timeout_c)) begin
          captured_q[i] <= 1'b1;
          rise_q[i]     <= chg_cnt_q;
        end
      end
    end
  end

`ifdef CAP_DEBOUNCE_EN
  localparam logic [1:0] DEB_LIMIT = 2'(DEBOUNCE_SCANS - 1);

  logic [1:0] agree_q [NUM_PADS];
  logic [1:0] agree_d [NUM_PADS];

  // Debounce counters: count consecutive disagreeing scans per pad.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PADS; i++) agree_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PADS; i++) agree_q[i] <= agree_d[i];
    end
  end
`endif

  // Output decode: drive/busy follow the next state; touch state resolves in EVAL.
  always_comb begin
    out_c     = (state_d == CHARGE);
    busy_c    = (state_d != IDLE);
    touched_c = touched;
    for (int i = 0; i < NUM_PADS; i++) begin
      raw_c[i] = (rise_q[i] >= CNT_W'(THRESHOLD));
    end
`ifdef CAP_DEBOUNCE_EN
    for (int i = 0; i < NUM_PADS; i++) begin
      agree_d[i] = agree_q[i];
      if (state_q == EVAL) begin
        if (raw_c[i] == touched[i]) begin
          agree_d[i] = '0;
        end else if (agree_q[i] == DEB_LIMIT) begin
          touched_c[i] = raw_c[i];
          agree_d[i]   = '0;
        end else begin
          agree_d[i] = agree_q[i] + 2'd1;
        end
      end
    end
`else
    if (state_q == EVAL) touched_c = raw_c;
`endif
  end

  // Registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      capacitive_sensors_out <= 1'b0;
      busy                   <= 1'b0;
      scan_done              <= 1'b0;
      touched                <= '0;
      touch_rise             <= '0;
    end else begin
      capacitive_sensors_out <= out_c;
      busy                   <= busy_c;
      scan_done              <= (state_q == EVAL);
      touched                <= touched_c;
      touch_rise             <= touched_c & ~touched;
    end
  end

endmodule

// File: tb/tb_capacitive_touch_scanner.sv
// Directed bench for capacitive_touch_scanner (DISCHARGE_CYCLES=8,
// TIMEOUT_CYCLES=63, THRESHOLD=20). Pads are driven high relative to the
// first charge cycle; a pad driven at charge count d reads high at d+2.
module tb_capacitive_touch_scanner;

`ifdef CAP_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [8:0] sensors = '0;
  logic       capacitive_sensors_out;
  logic [8:0] touched;
  logic [8:0] touch_rise;
  logic       scan_done;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int tr4   = 0;
  int len   = 0;
  logic [8:0][6:0] dly;
  logic       any_act;

  capacitive_touch_scanner #(
    .DISCHARGE_CYCLES(8),
    .TIMEOUT_CYCLES  (63),
    .THRESHOLD       (20),
    .DEBOUNCE_SCANS  (3)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .enable                (enable),
    .capacitive_sensors_in (sensors),
    .capacitive_sensors_out(capacitive_sensors_out),
    .touched               (touched),
    .touch_rise            (touch_rise),
    .scan_done             (scan_done),
    .busy                  (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold reset 3 cycles with enable high, then time the first DISCHARGE.
  task automatic do_reset();
    reset   = 1'b1;
    enable  = 1'b1;
    sensors = '0;
    repeat (3) @(negedge clock);
    check("rst_out", 32'(capacitive_sensors_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_touched", 32'(touched), 32'h000);
    check("rst_rise", 32'(touch_rise), 32'h000);
    check("rst_done", 32'(scan_done), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("dis_busy", 32'(busy), 32'd1);
    check("dis_out_first", 32'(capacitive_sensors_out), 32'd0);
    repeat (7) @(negedge clock);
    check("dis_out_last", 32'(capacitive_sensors_out), 32'd0);
    @(negedge clock);
    check("charge_on_time", 32'(capacitive_sensors_out), 32'd1);
  endtask

  // Drive pads through one CHARGE phase; len = number of cycles out was high.
  task automatic charge_phase(input logic [8:0][6:0] d, input int drop_k,
                              input int reset_k, output int n);
    int w;
    w = 0;
    while (capacitive_sensors_out !== 1'b1 && w < 100) begin
      @(negedge clock);
      w++;
    end
    check("charge_start", 32'(capacitive_sensors_out), 32'd1);
    check("charge_busy", 32'(busy), 32'd1);
    n = 0;
    while (capacitive_sensors_out === 1'b1 && n < 100) begin
      for (int i = 0; i < 9; i++) sensors[i] = (n >= int'(d[i]));
      if (n == drop_k) enable = 1'b0;
      if (n == reset_k) reset = 1'b1;
      @(negedge clock);
      n++;
    end
    sensors = '0;
  endtask

  // Wait for scan_done one cycle after EVAL and check the touch outputs.
  task automatic finish_scan(input string tag, input logic [8:0] exp_t, input logic [8:0] exp_tr);
    int w;
    w = 0;
    while (scan_done !== 1'b1 && w < 8) begin
      @(negedge clock);
      w++;
    end
    check({tag, "_done_lat"}, 32'(w), 32'd1);
    check({tag, "_touched"}, 32'(touched), 32'(exp_t));
    check({tag, "_touch_rise"}, 32'(touch_rise), 32'(exp_tr));
    tr4 = tr4 + (touch_rise[4] ? 1 : 0);
    @(negedge clock);
    check({tag, "_done_pulse"}, 32'(scan_done), 32'd0);
    check({tag, "_rise_pulse"}, 32'(touch_rise), 32'h000);
  endtask

  initial begin
    // Reset and first DISCHARGE timing.
    do_reset();

    // All pads high at count 3 -> rise 5, charge lasts 7 cycles, nothing touched.
    dly = {9{7'd3}};
    charge_phase(dly, -1, -1, len);
    check("s1_len", 32'(len), 32'd7);
    finish_scan("s1", 9'h000, 9'h000);

    // Pad 4 rises at 30, others at 5; repeated three times.
    dly[4] = 7'd28;
    charge_phase(dly, -1, -1, len);
    check("s2_len", 32'(len), 32'd32);
    finish_scan("s2", DEB ? 9'h000 : 9'h010, DEB ? 9'h000 : 9'h010);
    charge_phase(dly, -1, -1, len);
    check("s3_len", 32'(len), 32'd32);
    finish_scan("s3", DEB ? 9'h000 : 9'h010, 9'h000);
    charge_phase(dly, -1, -1, len);
    check("s4_len", 32'(len), 32'd32);
    finish_scan("s4", 9'h010, DEB ? 9'h010 : 9'h000);
    check("pad4_rise_pulses", 32'(tr4), 32'd1);

    // Threshold boundary: pad 1 rise 20 (touched), pad 2 rise 19 (not).
    dly[1] = 7'd18;
    dly[2] = 7'd17;
    charge_phase(dly, -1, -1, len);
    check("s5_len", 32'(len), 32'd32);
    finish_scan("s5", DEB ? 9'h010 : 9'h012, DEB ? 9'h000 : 9'h002);

    // Pad 0 never rises: timeout at 63, rise 63 counts as touched.
    dly = {9{7'd3}};
    dly[0] = 7'd99;
    charge_phase(dly, -1, -1, len);
    check("s6_len", 32'(len), 32'd64);
    finish_scan("s6", DEB ? 9'h010 : 9'h001, DEB ? 9'h000 : 9'h001);

    // Reset at count 10 of CHARGE aborts the scan immediately.
    charge_phase(dly, -1, 10, len);
    check("s7_len", 32'(len), 32'd11);
    check("s7_out", 32'(capacitive_sensors_out), 32'd0);
    check("s7_busy", 32'(busy), 32'd0);
    check("s7_touched", 32'(touched), 32'h000);
    check("s7_done", 32'(scan_done), 32'd0);
    do_reset();

    // Enable dropped at count 2: scan still completes, then IDLE.
    dly = {9{7'd3}};
    charge_phase(dly, 2, -1, len);
    check("s8_len", 32'(len), 32'd7);
    finish_scan("s8", 9'h000, 9'h000);
    check("s8_idle_busy", 32'(busy), 32'd0);
    check("s8_idle_out", 32'(capacitive_sensors_out), 32'd0);
    any_act = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (busy !== 1'b0 || capacitive_sensors_out !== 1'b0 || scan_done !== 1'b0) any_act = 1'b1;
    end
    check("s8_stays_idle", 32'(any_act), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
